digit_packer: RTL
=================

DIGIT_PACKER -- requirements
Module: digit_packer

Interface
REQ-001 The block SHALL have parameter DIGIT_W, default 4, giving the bits per digit.
REQ-002 The block SHALL have parameter NUM_DIGITS, default 4, giving the maximum digits held (>=2).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port digit_in  input  DIGIT_W  the digit value presented.
REQ-006 The block SHALL have port digit_valid  input  1  a digit_in entry request this cycle.
REQ-007 The block SHALL have port backspace  input  1  a request to remove the most recent digit.
REQ-008 The block SHALL have port clear  input  1  a request to discard the entry buffer.
REQ-009 The block SHALL have port enter  input  1  a request to commit the entry buffer to the output register.
REQ-010 The block SHALL have port out_ready  input  1  consumer acceptance of out_value.
REQ-011 The block SHALL have port acc  output  NUM_DIGITS*DIGIT_W  the live entry buffer (registered).
REQ-012 The block SHALL have port count  output  $clog2(NUM_DIGITS+1)  the digits currently held.
REQ-013 The block SHALL have ports empty and full  output  1 each  count==0 and count==NUM_DIGITS, respectively.
REQ-014 The block SHALL have port out_value  output  NUM_DIGITS*DIGIT_W  the committed number.
REQ-015 The block SHALL have port out_valid  output  1  out_value holds an unconsumed commit.
REQ-016 The block SHALL have port ovf  output  1  a one-cycle pulse when a digit is dropped because the buffer is full.
REQ-017 The block SHALL have port err  output  1  a one-cycle pulse when a digit is rejected as invalid (see REQ-033).

Function
REQ-018 The block SHALL have the states EMPTY (count 0), ENTRY (0<count<NUM_DIGITS), and FULL (count==NUM_DIGITS), with the state register consistent with count at all times.
REQ-019 Per cycle, the block SHALL act on at most one request, with priority clear > enter > backspace > digit_valid; lower-priority requests in the same cycle SHALL be ignored and SHALL NOT pulse ovf or err.
REQ-020 An accepted digit SHALL give acc <= {acc[NUM_DIGITS*DIGIT_W-DIGIT_W-1:0], digit_in} and count+1, so the newest digit occupies bits [DIGIT_W-1:0].
REQ-021 A digit presented in state FULL SHALL leave acc and count unchanged and SHALL pulse ovf for 1 cycle.
REQ-022 Backspace SHALL make acc logically shift right by DIGIT_W (zero fill) and decrement count.
REQ-023 Backspace in state EMPTY SHALL have no effect.
REQ-024 Clear SHALL set acc=0 and count=0, SHALL leave out_value/out_valid untouched, and SHALL pulse neither ovf nor err.
REQ-025 Enter SHALL be accepted only when out_valid==0 or out_ready==1 in the same cycle.
REQ-026 On an accepted enter: out_value<=acc, out_valid<=1, acc<=0, count<=0; enter in EMPTY SHALL commit zero.
REQ-027 An enter not accepted SHALL be ignored, with acc held and out_value unchanged.
REQ-028 out_valid SHALL fall the cycle after out_valid&&out_ready unless an enter is accepted in that same cycle, in which case it SHALL stay 1 with the new value.
REQ-029 All effects SHALL be visible at the outputs one cycle after the request edge; the block SHALL contain no combinational input-to-output paths.

Reset
REQ-030 When reset is asserted, the block SHALL immediately, regardless of clk, set acc=0, count=0, state=EMPTY, out_value=0, out_valid=0, ovf=0, err=0.
REQ-031 Reset asserted mid-entry or with out_valid pending SHALL discard everything; no commit SHALL survive it.
REQ-032 The first request acted on after reset SHALL be the one on the first rising clk edge after reset deasserts.

Configuration
REQ-033 When macro DIGIT_PACKER_BCD_CHECK_EN is defined, a digit_valid acted on with digit_in>9 SHALL leave acc/count unchanged and pulse err for 1 cycle, and FULL SHALL take precedence (ovf only).
REQ-034 When DIGIT_PACKER_BCD_CHECK_EN is not defined, every digit value SHALL be accepted and err SHALL be tied to 0.

Verification (DIGIT_W=4, NUM_DIGITS=4)
REQ-035 The bench SHALL cover: digits 1,2,3 -> acc=0x0123, count=3, state ENTRY; then 4 -> acc=0x1234, full=1.
REQ-036 The bench SHALL cover: from acc=0x1234, digit 5 -> acc unchanged, ovf high exactly 1 cycle; then backspace -> acc=0x0123, count=3.
REQ-037 The bench SHALL cover: enter with acc=0x0123, out_ready=0 -> out_value=0x0123, out_valid=1, acc=0; a second enter with acc=0x0045 -> ignored, acc stays 0x0045; out_ready=1 with enter in the same cycle -> out_value=0x0045, out_valid stays 1.
REQ-038 The bench SHALL cover: clear+enter+digit in the same cycle with acc=0x0012 -> acc=0, count=0, out_valid unchanged, no ovf/err.
REQ-039 The bench SHALL cover: reset asserted between clock edges with count=2, out_valid=1 -> all outputs 0 before the next clk edge.
REQ-040 The bench SHALL cover, with DIGIT_PACKER_BCD_CHECK_EN defined: digit 0xA -> err 1-cycle pulse, acc unchanged; without it, acc shifts in 0xA and err stays 0.

Source files
------------

// File: rtl/digit_packer.sv
// -----------------------------------------------------------------------------
// digit_packer
//
// Packs a stream of keypad-style digits into an entry buffer and commits the
// buffer to an output register on enter. The newest digit sits in the least
// significant DIGIT_W bits. Backspace drops the newest digit. Clear empties
// the buffer. A committed value is held in out_value until the consumer takes it.
//
// Optional feature (macro DIGIT_PACKER_BCD_CHECK_EN):
//   When it is defined, digits greater than 9 are rejected with a one-cycle err
//   pulse. When it is undefined, every digit value is accepted and err is tied to 0.
//
// Parameters:
//   DIGIT_W      bits per digit
//   NUM_DIGITS   maximum digits held in the entry buffer (>= 2)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   digit_in     digit value presented
//   digit_valid  digit entry request
//   backspace    remove the newest digit
//   clear        discard the entry buffer
//   enter        commit the entry buffer to out_value
//   out_ready    consumer accepts out_value this cycle
//   acc          live entry buffer (registered)
//   count        number of digits held
//   empty, full  count == 0 and count == NUM_DIGITS
//   out_value    committed number
//   out_valid    out_value holds an unconsumed commit
//   ovf          one-cycle pulse: digit dropped because the buffer was full
//   err          one-cycle pulse: digit rejected as non-BCD
//   state_dbg    FSM state (0 = EMPTY, 1 = ENTRY, 2 = FULL)
//
// Handshake: out_value is transferred on any rising edge where out_valid and
// out_ready are both 1. out_valid then falls, unless an enter is accepted in
// the same cycle. In that case out_valid stays high and carries the new value.
// An enter is accepted only when out_valid is 0, or when out_ready is 1 in
// the same cycle.
//
// Per cycle, at most one request is acted on. The priority is
// clear > enter > backspace > digit_valid. Lower-priority requests in the
// same cycle are dropped silently.
// -----------------------------------------------------------------------------
module digit_packer #(
  parameter int DIGIT_W    = 4,
  parameter int NUM_DIGITS = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DIGIT_W-1:0]                digit_in,
  input  logic                              digit_valid,
  input  logic                              backspace,
  input  logic                              clear,
  input  logic                              enter,
  input  logic                              out_ready,
  output logic [NUM_DIGITS*DIGIT_W-1:0]     acc,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   count,
  output logic                              empty,
  output logic                              full,
  output logic [NUM_DIGITS*DIGIT_W-1:0]     out_value,
  output logic                              out_valid,
  output logic                              ovf,
  output logic                              err,
  output logic [1:0]                        state_dbg
);

  localparam int ACC_W = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_DIGITS);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ENTRY = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [ACC_W-1:0]   acc_q,       acc_d;
  logic [CNT_W-1:0]   count_q,     count_d;
  logic [ACC_W-1:0]   out_value_q, out_value_d;
  logic               out_valid_q, out_valid_d;
  logic               ovf_q,       ovf_d;
`ifdef DIGIT_PACKER_BCD_CHECK_EN
  logic               err_q,       err_d;
`endif

  logic enter_ok;
  assign enter_ok = !out_valid_q || out_ready;

  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    out_value_d = out_value_q;
    out_valid_d = out_valid_q;
    ovf_d       = 1'b0;
`ifdef DIGIT_PACKER_BCD_CHECK_EN
    err_d       = 1'b0;
`endif

    // A consumer transfer empties the output register. An accepted enter
    // below overrides this and reloads the register in the same cycle.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clear) begin
      acc_d   = '0;
      count_d = '0;
    end else if (enter) begin
      // A refused enter still takes the cycle's slot, so nothing else happens.
      if (enter_ok) begin
        out_value_d = acc_q;
        out_valid_d = 1'b1;
        acc_d       = '0;
        count_d     = '0;
      end
    end else if (backspace) begin
      if (count_q != '0) begin
        acc_d   = acc_q >> DIGIT_W;
        count_d = count_q - CNT_W'(1);
      end
    end else if (digit_valid) begin
      // A full buffer wins over the BCD check, so only ovf pulses.
      if (count_q == MAX_CNT) begin
        ovf_d = 1'b1;
`ifdef DIGIT_PACKER_BCD_CHECK_EN
      end else if (32'(digit_in) > 32'd9) begin
        err_d = 1'b1;
`endif
      end else begin
        acc_d   = {acc_q[ACC_W-DIGIT_W-1:0], digit_in};
        count_d = count_q + CNT_W'(1);
      end
    end

    // The state always follows the next count, so the two cannot diverge.
    if (count_d == '0) begin
      state_d = S_EMPTY;
    end else if (count_d == MAX_CNT) begin
      state_d = S_FULL;
    end else begin
      state_d = S_ENTRY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      acc_q       <= '0;
      count_q     <= '0;
      out_value_q <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef DIGIT_PACKER_BCD_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_value_q <= out_value_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
`ifdef DIGIT_PACKER_BCD_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign acc       = acc_q;
  assign count     = count_q;
  assign empty     = (state_q == S_EMPTY);
  assign full      = (state_q == S_FULL);
  assign out_value = out_value_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;
`ifdef DIGIT_PACKER_BCD_CHECK_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule
